ppu_vram_bus_ctrl: RTL

- Sequences the PPU's external multiplexed VRAM bus: PPU_AD[13:0] plus ALE, RD and WR.
- Arbitrates that bus between two requesters:
  - the rendering fetch engine (nametable, attribute and pattern fetches);
  - the CPU-side PPUDATA ($2007) access path.
- Sits between those requesters and the chip pins. Palette ($3F00+) decode happens upstream; every request reaching this block goes to the external bus.

---
 rtl/ppu_vram_bus_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ppu_vram_bus_ctrl.sv
// rtl/ppu_vram_bus_ctrl.sv - PPU VRAM multiplexed bus sequencer with render/CPU arbitration
module ppu_vram_bus_ctrl #(
    parameter int CPU_MAX_WAIT = 16,
    parameter int WAIT_W       = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rnd_req,
    input  logic [13:0] rnd_addr,
    output logic        rnd_ack,
    output logic        rnd_rvalid,
    output logic [7:0]  rnd_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    output logic [13:0] ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t             state;
    state_t             state_d;
    logic               grant_go;
    logic               grant_cpu;
    logic               cpu_starved;
    logic [13:0]        grant_addr;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               own_cpu;
    logic               own_we;
    logic [7:0]         lat_wdata;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A starved CPU beats render; otherwise render beats CPU.
    always_comb begin
        state_d     = state;
        grant_go    = 1'b0;
        grant_cpu   = 1'b0;
        cpu_starved = cpu_req && (wait_cnt >= WAIT_W'(CPU_MAX_WAIT));
        case (state)
            ADDR: state_d = DATA;
            default: begin
                if (cpu_starved) begin
                    grant_go  = 1'b1;
                    grant_cpu = 1'b1;
                end else if (rnd_req) begin
                    grant_go  = 1'b1;
                end else if (cpu_req) begin
                    grant_go  = 1'b1;
                    grant_cpu = 1'b1;
                end
                state_d = grant_go ? ADDR : IDLE;
            end
        endcase
        grant_addr = grant_cpu ? cpu_addr : rnd_addr;
    end

    // Pin outputs are registered off the next state so nothing is combinational to the pads.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rnd_ack    <= 1'b0;
            rnd_rvalid <= 1'b0;
            rnd_rdata  <= 8'h00;
            cpu_ack    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 8'h00;
            ad_out     <= 14'h0000;
            ad_oe      <= 1'b0;
            ale        <= 1'b0;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            busy       <= 1'b0;
            wait_cnt   <= '0;
            own_cpu    <= 1'b0;
            own_we     <= 1'b0;
            lat_wdata  <= 8'h00;
        end else begin
            rnd_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            rnd_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;

            if (state == DATA && !own_we) begin
                if (own_cpu) begin
                    cpu_rdata  <= ad_in;
                    cpu_rvalid <= 1'b1;
                end else begin
                    rnd_rdata  <= ad_in;
                    rnd_rvalid <= 1'b1;
                end
            end

            case (state_d)
                ADDR: begin
                    own_cpu   <= grant_cpu;
                    own_we    <= grant_cpu && cpu_we;
                    lat_wdata <= cpu_wdata;
                    ad_out    <= grant_addr;
                    ad_oe     <= 1'b1;
                    ale       <= 1'b1;
                    rd_n      <= 1'b1;
                    wr_n      <= 1'b1;
                    busy      <= 1'b1;
                    cpu_ack   <= grant_cpu;
                    rnd_ack   <= !grant_cpu;
                end
                DATA: begin
                    ale  <= 1'b0;
                    ad_oe <= own_we;
                    rd_n <= own_we;
                    wr_n <= !own_we;
                    busy <= 1'b1;
                    if (own_we) begin
                        ad_out[7:0] <= lat_wdata;
                    end
                end
                default: begin
                    ale   <= 1'b0;
                    ad_oe <= 1'b0;
                    rd_n  <= 1'b1;
                    wr_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase

            if (!cpu_req || cpu_ack) begin
                wait_cnt <= '0;
            end else if (!(grant_go && grant_cpu) && (wait_cnt < WAIT_W'(CPU_MAX_WAIT))) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule
